// File: rtl/spi_ram_pkg.sv
// Shared types for the burst-capable SPI RAM: command encoding and per-channel arming state.
package spi_ram_pkg;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic {
    DISARMED = 1'b0,
    ARMED    = 1'b1
  } arm_e;

endpackage

// File: rtl/spi_ram_rd_pipe.sv
// Read-return pipeline: RD_LATENCY-deep valid/data shift register with synchronous flush on rst_n.
// The last data stage only loads on a valid beat, so out_data holds between pulses.
module spi_ram_rd_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [RD_LATENCY-1:0] vld;
  logic [DATA_WIDTH-1:0] dat [RD_LATENCY];

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) dat[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      if (in_valid) dat[0] <= in_data;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) dat[i] <= dat[i-1];
      end
    end
  end

  assign out_valid = vld[RD_LATENCY-1];
  assign out_data  = dat[RD_LATENCY-1];

endmodule

// File: rtl/spi_ram_burst.sv
// SPI-slave RAM with independent write/read pointers, optional burst auto-increment,
// configurable read latency and a registered error pulse for illegal commands.
module spi_ram_burst
  import spi_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int AUTO_INC   = 0,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH+1:0] din,
  input  logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  tx_valid,
  output logic                  err
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  cmd_e                  cmd;
  logic [DATA_WIDTH-1:0] payload;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic                  addr_ok;

  arm_e                  wr_state, wr_state_next;
  arm_e                  rd_state, rd_state_next;
  logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_next;
  logic [ADDR_WIDTH-1:0] rd_ptr, rd_ptr_next;
  logic                  mem_we;
  logic                  rd_fire;
  logic                  err_next;
  logic [DATA_WIDTH-1:0] rd_word;

  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    if (32'(p) == MEM_DEPTH - 1) return '0;
    return p + ADDR_WIDTH'(1);
  endfunction

  assign cmd     = cmd_e'(din[DATA_WIDTH+1:DATA_WIDTH]);
  assign payload = din[DATA_WIDTH-1:0];
  assign addr_in = payload[ADDR_WIDTH-1:0];
  assign addr_ok = 32'(addr_in) < MEM_DEPTH;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    wr_state_next = wr_state;
    rd_state_next = rd_state;
    wr_ptr_next   = wr_ptr;
    rd_ptr_next   = rd_ptr;
    mem_we        = 1'b0;
    rd_fire       = 1'b0;
    err_next      = 1'b0;
    if (rx_valid) begin
      unique case (cmd)
        CMD_WR_ADDR: begin
          if (addr_ok) begin
            wr_ptr_next   = addr_in;
            wr_state_next = ARMED;
          end else err_next = 1'b1;
        end
        CMD_WR_DATA: begin
          if (wr_state == ARMED) begin
            mem_we = 1'b1;
            if (AUTO_INC != 0) wr_ptr_next = ptr_inc(wr_ptr);
          end else err_next = 1'b1;
        end
        CMD_RD_ADDR: begin
          if (addr_ok) begin
            rd_ptr_next   = addr_in;
            rd_state_next = ARMED;
          end else err_next = 1'b1;
        end
        CMD_RD_DATA: begin
          if (rd_state == ARMED) begin
            rd_fire = 1'b1;
            if (AUTO_INC != 0) rd_ptr_next = ptr_inc(rd_ptr);
          end else err_next = 1'b1;
        end
        default: err_next = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_state <= DISARMED;
      rd_state <= DISARMED;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      err      <= 1'b0;
    end else begin
      wr_state <= wr_state_next;
      rd_state <= rd_state_next;
      wr_ptr   <= wr_ptr_next;
      rd_ptr   <= rd_ptr_next;
      err      <= err_next;
    end
  end

  // NOTE: the array is deliberately left out of reset so it maps onto RAM primitives.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr] <= payload;
  end

  // A write at edge N lands before any read sampled at edge N+1, so no bypass is needed.
  assign rd_word = mem[rd_ptr];

  spi_ram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_fire),
    .in_data   (rd_word),
    .out_valid (tx_valid),
    .out_data  (dout)
  );

endmodule

// File: tb/tb_spi_ram_burst.sv
// Scoreboard bench for spi_ram_burst (AUTO_INC=1, MEM_DEPTH=200, RD_LATENCY=2): the driver queues
// expected read/err pulses with their due cycle, and a negedge monitor checks every cycle.
module tb_spi_ram_burst;

  localparam int DW  = 8;
  localparam int LAT = 2;

  typedef struct {
    int          due;
    logic [DW-1:0] data;
  } rd_exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW+1:0] din;
  logic          rx_valid;
  logic [DW-1:0] dout;
  logic          tx_valid;
  logic          err;

  int      cyc = 0;
  int      tests = 0;
  int      fails = 0;
  rd_exp_t rd_q[$];
  int      err_q[$];
  rd_exp_t mon_e;
  int      mon_due;

  spi_ram_burst #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (8),
    .MEM_DEPTH  (200),
    .AUTO_INC   (1),
    .RD_LATENCY (LAT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .rx_valid (rx_valid),
    .dout     (dout),
    .tx_valid (tx_valid),
    .err      (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Issue one command next cycle and queue the response it must produce.
  task automatic send(input logic [1:0] c, input logic [7:0] p,
                      input bit exp_err, input bit exp_rd, input logic [7:0] exp_d);
    rd_exp_t e;
    @(posedge clk); #1;
    din      = {c, p};
    rx_valid = 1'b1;
    if (exp_err) err_q.push_back(cyc + 1);
    if (exp_rd) begin
      e.due  = cyc + LAT;
      e.data = exp_d;
      rd_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rx_valid = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (rd_q.size() != 0 && rd_q[0].due == cyc) begin
      mon_e = rd_q.pop_front();
      check("rd_return", tx_valid === 1'b1 && dout === mon_e.data,
            {23'd0, tx_valid, dout}, {24'd1, mon_e.data});
    end else begin
      check("no_tx", tx_valid === 1'b0, {31'd0, tx_valid}, 32'd0);
    end
    if (err_q.size() != 0 && err_q[0] == cyc) begin
      mon_due = err_q.pop_front();
      check("err_pulse", err === 1'b1, {31'd0, err}, 32'd1);
    end else begin
      check("no_err", err === 1'b0, {31'd0, err}, 32'd0);
    end
  end

  localparam logic [1:0] WA = 2'b00, WD = 2'b01, RA = 2'b10, RD = 2'b11;

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; din = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", dout === 8'h00, {24'd0, dout}, 32'd0);
    check("rst_tx_valid", tx_valid === 1'b0, {31'd0, tx_valid}, 32'd0);
    check("rst_err", err === 1'b0, {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Data commands on disarmed channels.
    send(RD, 8'h5A, 1, 0, 8'h00);
    send(WD, 8'h77, 1, 0, 8'h00);
    idle(3);

    // Single write/read round trip.
    send(WA, 8'h10, 0, 0, 8'h00);
    send(WD, 8'hA5, 0, 0, 8'h00);
    send(RA, 8'h10, 0, 0, 8'h00);
    send(RD, 8'h00, 0, 1, 8'hA5);
    idle(4);

    // Burst across the MEM_DEPTH wrap: 198, 199, 0.
    send(WA, 8'd198, 0, 0, 8'h00);
    send(WD, 8'h11, 0, 0, 8'h00);
    send(WD, 8'h22, 0, 0, 8'h00);
    send(WD, 8'h33, 0, 0, 8'h00);
    send(RA, 8'd198, 0, 0, 8'h00);
    send(RD, 8'hFF, 0, 1, 8'h11);
    send(RD, 8'hFF, 0, 1, 8'h22);
    send(RD, 8'hFF, 0, 1, 8'h33);
    idle(4);

    // Out-of-range addresses must leave pointers untouched (wr_ptr=1, rd_ptr=1 here).
    send(WA, 8'd250, 1, 0, 8'h00);
    send(WD, 8'h44, 0, 0, 8'h00);
    send(RA, 8'd250, 1, 0, 8'h00);
    send(RD, 8'h00, 0, 1, 8'h44);
    send(RA, 8'd199, 0, 0, 8'h00);
    send(RD, 8'h00, 0, 1, 8'h22);
    send(RA, 8'd200, 1, 0, 8'h00);
    send(RD, 8'h00, 0, 1, 8'h33);
    idle(4);

    // rx_valid low: every command type presented, none may act.
    send(WA, 8'h10, 0, 0, 8'h00);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      rx_valid = 1'b0;
      din      = {2'(i), 8'($urandom)};
    end
    send(RA, 8'h10, 0, 0, 8'h00);
    send(RD, 8'h00, 0, 1, 8'hA5);
    send(RA, 8'd198, 0, 0, 8'h00);
    send(RD, 8'h00, 0, 1, 8'h11);
    idle(4);

    // Reset one cycle after a legal read: the in-flight beat must vanish.
    send(RA, 8'h10, 0, 0, 8'h00);
    send(RD, 8'h00, 0, 0, 8'h00);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_dout", dout === 8'h00, {24'd0, dout}, 32'd0);
    rst_n = 1'b1;
    idle(4);
    send(RD, 8'h00, 1, 0, 8'h00);
    send(WD, 8'h99, 1, 0, 8'h00);
    idle(6);

    check("drain_rd", rd_q.size() == 0, rd_q.size(), 32'd0);
    check("drain_err", err_q.size() == 0, err_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
